axi_iob_slave: RTL
==================

// Module: axi_iob_slave
// PURPOSE
//  AXI4 slave (responder) that accepts single and burst transactions from an external AXI
//  master and replays each beat as a request on an IOb native master port.
//  It is the responder end of the AXI interface that ext_mem drives as initiator.
//  Lets a host/debug AXI master reach the internal SRAM/peripheral bus; sits in front of iob_split.
//  One outstanding transaction at a time.
// PARAMETERS
//  ADDR_W   32  AXI and native address width (byte address)
//  DATA_W   32  data width; DATA_W/8 strobe bits
//  ID_W     1   AXI ID width
// PORTS
//  clk            in   1         system clock
//  rst_n          in   1         asynchronous active-low reset
//  s_axi_aw*      in/out  -      awid[ID_W] awaddr[ADDR_W] awlen[8] awsize[3] awburst[2] awvalid in; awready out
//  s_axi_w*       in/out  -      wdata[DATA_W] wstrb[DATA_W/8] wlast wvalid in; wready out
//  s_axi_b*       in/out  -      bid[ID_W] bresp[2] bvalid out; bready in
//  s_axi_ar*      in/out  -      arid arlen arsize arburst araddr arvalid in; arready out
//  s_axi_r*       in/out  -      rid rdata[DATA_W] rresp[2] rlast rvalid out; rready in
//  iob_valid      out  1         native request valid; held until iob_ready
//  iob_addr       out  ADDR_W    native byte address, low log2(DATA_W/8) bits forced 0
//  iob_wdata      out  DATA_W    write data
//  iob_wstrb      out  DATA_W/8  byte enables; all-zero = read
//  iob_rdata      in   DATA_W    read data, valid when iob_ready=1
//  iob_ready      in   1         request complete (same cycle as iob_valid allowed)
// BEHAVIOUR
//  Reset: every output 0, FSM IDLE, priority pointer = write; reset mid-burst drops iob_valid
//   immediately and abandons the burst (no B/R response after reset).
//  FSM: IDLE -> WDAT -> WREQ -> (WDAT | BRESP) -> IDLE ; IDLE -> RREQ -> RDAT -> (RREQ | IDLE).
//  IDLE: awready/arready asserted only for the selected channel; AW and AR both valid -> alternate
//   (round-robin, write first after reset). Handshake latches id, addr, len, size, burst; beat cnt=0.
//  WDAT: wready=1; on W handshake latch wdata/wstrb, wready drops next cycle, -> WREQ.
//  WREQ: iob_valid=1 with latched addr/wdata/wstrb; on iob_ready advance address, cnt++;
//   cnt==len -> BRESP else -> WDAT. Min 2 cycles/beat.
//  wlast must equal (cnt==len); mismatch sets sticky err; beat count is governed by awlen only.
//  BRESP: bvalid=1, bid=latched id, bresp=err?SLVERR(2'b10):OKAY(2'b00); hold until bready -> IDLE.
//  RREQ: iob_valid=1, iob_wstrb=0; on iob_ready register rdata -> RDAT.
//  RDAT: rvalid=1, rid, rresp=OKAY, rlast=(cnt==len); hold all stable until rready;
//   then cnt++, last -> IDLE else -> RREQ. Latency AR handshake(N) -> iob_valid N+1 ->
//   rvalid N+2 when iob_ready is immediate.
//  Address: FIXED(00) constant; INCR(01) += 1<<size; WRAP(10) wraps within (len+1)<<size aligned
//   window; reserved(11) treated as INCR with err set (SLVERR on every R beat / B).
//  awsize/arsize > log2(DATA_W/8): err set, transfer still performed at full width.
//  Arithmetic on ADDR_W bits, wrapping mod 2^ADDR_W; 4KB crossing is not checked.
//  len=0 (single beat) is the same path with rlast=1 on the first beat.
// STRUCTURE
//  Shared header axi_defs.vh: AXI_BURST_FIXED/INCR/WRAP, AXI_RESP_OKAY/SLVERR, state encodings.
//  Sub-module axi_burst_addr: combinational next-address from (addr,size,len,burst) for FIXED/INCR/WRAP;
//   instantiated once and shared by both directions.
// TESTING
//  1 Single write awaddr=0x100 len=0 wdata=0xDEADBEEF wstrb=F -> one iob write @0x100, bresp=OKAY, bid=awid.
//  2 INCR read araddr=0x200 len=3 size=2, iob_ready after 0..3 random cycles -> iob addrs
//    0x200,204,208,20C; 4 R beats in order, rlast only on beat 4; rready stalls leave rdata stable.
//  3 WRAP read araddr=0x1C len=3 size=2 -> iob addrs 0x1C,0x10,0x14,0x18.
//  4 AW and AR valid in same cycle, twice -> write served, then read, then write (alternation).
//  5 Write len=1 with wlast on beat 1 -> 2 iob writes, bresp=SLVERR; next clean write returns OKAY.
//  6 rst_n low during beat 2 of len=7 read -> all outputs 0 asynchronously; after release a new
//    single read completes normally with no stale R beats.

Source files
------------

// File: rtl/axi_iob_slave_pkg.sv
// axi_iob_slave_pkg: shared definitions for the AXI4-to-IOb slave bridge.
//   - AXI burst type and response encodings
//   - bridge FSM state type
//   - ax_err(): flags request attributes the bridge serves but must answer with SLVERR
package axi_iob_slave_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
  localparam logic [1:0] AXI_BURST_RSVD  = 2'b11;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDAT,
    ST_WREQ,
    ST_BRESP,
    ST_RREQ,
    ST_RDAT
  } state_t;

  // Reserved burst type (served as INCR) and beats wider than the bus (served
  // at full width) both complete, but report SLVERR.
  function automatic logic ax_err(input logic [2:0] size, input logic [1:0] burst,
                                  input int unsigned size_max);
    return (burst == AXI_BURST_RSVD) || (32'(size) > size_max);
  endfunction

endpackage

// File: rtl/axi_iob_slave_if.sv
// axi_iob_slave_if: AXI4 bus between an external master and axi_iob_slave.
//   AW: awid awaddr awlen awsize awburst awvalid -> / <- awready
//   W : wdata wstrb wlast wvalid               -> / <- wready
//   B : <- bid bresp bvalid                       /  -> bready
//   AR: arid araddr arlen arsize arburst arvalid -> / <- arready
//   R : <- rid rdata rresp rlast rvalid           /  -> rready
// Modports: master (initiator side), slave (responder side).
interface axi_iob_slave_if
  import axi_iob_slave_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 1
);

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_iob_slave_burst_addr.sv
// axi_burst_addr: combinational AXI next-beat address.
//   addr      in  current beat byte address
//   size      in  log2(bytes per beat)
//   len       in  beats - 1
//   burst     in  FIXED / INCR / WRAP (reserved handled as INCR)
//   next_addr out address of the following beat, modulo 2^ADDR_W
module axi_burst_addr
  import axi_iob_slave_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    incr_addr = addr + (ADDR_W'(1) << size);
    // Wrap window is (len+1)<<size bytes, aligned to its own size: keep the
    // window base from addr and take the offset from the incremented address.
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    case (burst)
      AXI_BURST_FIXED: next_addr = addr;
      AXI_BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:         next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_iob_slave.sv
// axi_iob_slave: AXI4 responder that replays every accepted beat as one IOb
// native request. One outstanding transaction; AW/AR collisions alternate,
// write first after reset.
//   clk, rst_n     clock, asynchronous active-low reset
//   s_axi          AXI4 slave modport (AW/W/B/AR/R channels)
//   iob_valid      out native request valid, held until iob_ready
//   iob_addr       out beat address, low log2(DATA_W/8) bits forced to 0
//   iob_wdata      out write data
//   iob_wstrb      out byte enables, all-zero for reads
//   iob_rdata      in  read data, sampled with iob_ready
//   iob_ready      in  request complete (may coincide with iob_valid)
module axi_iob_slave
  import axi_iob_slave_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  axi_iob_slave_if.slave      s_axi,
  output logic                iob_valid,
  output logic [ADDR_W-1:0]   iob_addr,
  output logic [DATA_W-1:0]   iob_wdata,
  output logic [DATA_W/8-1:0] iob_wstrb,
  input  logic [DATA_W-1:0]   iob_rdata,
  input  logic                iob_ready
);

  localparam int unsigned SIZE_MAX = $clog2(DATA_W / 8);

  state_t              state, state_nxt;
  logic                rd_prio;     // 1: a read wins the next AW/AR collision
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [7:0]          len_q;
  logic [7:0]          cnt_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic                err_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   rdata_q;

  logic sel_w;
  logic aw_rdy, ar_rdy, w_rdy, b_vld, r_vld, iob_vld;
  logic last_beat;
  logic iob_hs;

  assign last_beat = (cnt_q == len_q);
  assign iob_hs    = iob_vld && iob_ready;

  axi_burst_addr #(
    .ADDR_W(ADDR_W)
  ) u_burst_addr (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (addr_nxt)
  );

  always_comb begin
    state_nxt = state;
    aw_rdy    = 1'b0;
    ar_rdy    = 1'b0;
    w_rdy     = 1'b0;
    b_vld     = 1'b0;
    r_vld     = 1'b0;
    iob_vld   = 1'b0;
    sel_w     = s_axi.awvalid && (!s_axi.arvalid || !rd_prio);
    case (state)
      ST_IDLE: begin
        aw_rdy = sel_w;
        ar_rdy = s_axi.arvalid && !sel_w;
        if (aw_rdy)      state_nxt = ST_WDAT;
        else if (ar_rdy) state_nxt = ST_RREQ;
      end
      ST_WDAT: begin
        w_rdy = 1'b1;
        if (s_axi.wvalid) state_nxt = ST_WREQ;
      end
      ST_WREQ: begin
        iob_vld = 1'b1;
        if (iob_ready) state_nxt = last_beat ? ST_BRESP : ST_WDAT;
      end
      ST_BRESP: begin
        b_vld = 1'b1;
        if (s_axi.bready) state_nxt = ST_IDLE;
      end
      ST_RREQ: begin
        iob_vld = 1'b1;
        if (iob_ready) state_nxt = ST_RDAT;
      end
      ST_RDAT: begin
        r_vld = 1'b1;
        if (s_axi.rready) state_nxt = last_beat ? ST_IDLE : ST_RREQ;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rd_prio <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (aw_rdy) begin
        id_q    <= s_axi.awid;
        addr_q  <= s_axi.awaddr;
        len_q   <= s_axi.awlen;
        size_q  <= s_axi.awsize;
        burst_q <= s_axi.awburst;
        err_q   <= ax_err(s_axi.awsize, s_axi.awburst, SIZE_MAX);
      end else if (ar_rdy) begin
        id_q    <= s_axi.arid;
        addr_q  <= s_axi.araddr;
        len_q   <= s_axi.arlen;
        size_q  <= s_axi.arsize;
        burst_q <= s_axi.arburst;
        err_q   <= ax_err(s_axi.arsize, s_axi.arburst, SIZE_MAX);
      end
      if (aw_rdy || ar_rdy) begin
        rd_prio <= aw_rdy;
        cnt_q   <= '0;
      end
      // Beat count follows awlen; a misplaced wlast only poisons the response.
      if (w_rdy && s_axi.wvalid) begin
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
        if (s_axi.wlast != last_beat) err_q <= 1'b1;
      end
      if (iob_hs) begin
        addr_q <= addr_nxt;
        if (state == ST_RREQ) rdata_q <= iob_rdata;
      end
      if ((iob_hs && state == ST_WREQ) || (r_vld && s_axi.rready)) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign s_axi.awready = aw_rdy;
  assign s_axi.arready = ar_rdy;
  assign s_axi.wready  = w_rdy;
  assign s_axi.bvalid  = b_vld;
  assign s_axi.bid     = id_q;
  assign s_axi.bresp   = (b_vld && err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign s_axi.rvalid  = r_vld;
  assign s_axi.rid     = id_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = (r_vld && err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign s_axi.rlast   = r_vld && last_beat;

  assign iob_valid = iob_vld;
  assign iob_addr  = addr_q & ~ADDR_W'(DATA_W / 8 - 1);
  assign iob_wdata = wdata_q;
  assign iob_wstrb = (state == ST_WREQ) ? wstrb_q : '0;

endmodule
